// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
//   start, op, a_in, b_in : request (op 0 = MULTU, 1 = DIVU)
//   busy, done, div0      : status; done is a one-cycle pulse
//   hi, lo                : result (product high/low or remainder/quotient)
// master = pipeline side issuing requests, slave = the sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply (MULTU) / divide (DIVU) sequencer for the EX
// stage. It owns no adder: each iteration borrows the shared 32-bit ALU
// (alu_op 0 = add, 1 = subtract), whose result returns combinationally on
// alu_o in the same cycle. Shift-add multiply, restoring divide, one bit per
// cycle, result in hi/lo.
// Ports:
//   clk, nrst    : rising-edge clock, synchronous active-low reset
//   bus (slave)  : start/op/a_in/b_in request, busy/done/div0/hi/lo status
//   alu_own      : high while this block drives the shared ALU
//   alu_a/alu_b  : ALU operands (zero when alu_own=0)
//   alu_op       : ALU opcode (zero when alu_own=0)
//   alu_o        : ALU result
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             nrst,
    muldiv_seq_if.slave      bus,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] operand;   // multiplicand in MUL, divisor in DIV
    logic [CNTW-1:0]  cnt;
    logic             busy_r;
    logic             done_r;
    logic             div0_r;
    logic             own_r;

    // Partial remainder shifted left by one, with the next dividend bit in.
    logic [WIDTH:0]   s;
    logic             ge;
    logic             carry;
    logic             last;

    assign s     = {hi_r, lo_r[WIDTH-1]};
    // s[WIDTH] set means s >= 2^WIDTH > divisor; the subtraction result then
    // still fits in WIDTH bits because the true difference is below the divisor.
    assign ge    = s[WIDTH] | (s[WIDTH-1:0] >= operand);
    // Unsigned overflow of hi + multiplicand, recovered from the wrapped sum.
    assign carry = (alu_o < hi_r);
    assign last  = (cnt == CNTW'(WIDTH - 1));

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'd0;
        if (state == MUL) begin
            alu_a  = hi_r;
            alu_b  = operand;
            alu_op = 3'd0;
        end else if (state == DIV) begin
            alu_a  = s[WIDTH-1:0];
            alu_b  = operand;
            alu_op = 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            hi_r    <= '0;
            lo_r    <= '0;
            operand <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            div0_r  <= 1'b0;
            own_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        div0_r <= 1'b0;
                        cnt    <= '0;
                        if (!bus.op) begin
                            operand <= bus.a_in;
                            hi_r    <= '0;
                            lo_r    <= bus.b_in;
                            own_r   <= 1'b1;
                            state   <= MUL;
                        end else if (bus.b_in != '0) begin
                            operand <= bus.b_in;
                            hi_r    <= '0;
                            lo_r    <= bus.a_in;
                            own_r   <= 1'b1;
                            state   <= DIV;
                        end else begin
                            // Divide by zero: answer immediately, ALU untouched.
                            hi_r   <= bus.a_in;
                            lo_r   <= '1;
                            div0_r <= 1'b1;
                            done_r <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                MUL: begin
                    if (lo_r[0]) begin
                        {hi_r, lo_r} <= {carry, alu_o, lo_r[WIDTH-1:1]};
                    end else begin
                        {hi_r, lo_r} <= {1'b0, hi_r, lo_r[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        own_r  <= 1'b0;
                        done_r <= 1'b1;
                        state  <= FIN;
                    end
                end
                DIV: begin
                    hi_r <= ge ? alu_o : s[WIDTH-1:0];
                    lo_r <= {lo_r[WIDTH-2:0], ge};
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        own_r  <= 1'b0;
                        done_r <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    // A start seen here is deliberately dropped.
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_own  = own_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.div0 = div0_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for unsigned 32-bit multiply (MULTU) and divide (DIVU) in the EX stage.
- Has no adder or subtractor of its own. It reuses the shared 32-bit ALU (aluop 0 = add, 1 = subtract) one iteration per cycle.
- Only a local carry/compare and shift registers sit inside the block.
- Result lands in hi/lo; the pipeline stalls on busy. The EX-stage ALU input mux selects this block's operands whenever alu_own=1.

Parameters:
- WIDTH, 32, operand width; iteration count = WIDTH; hi/lo each WIDTH bits.
- CNTW, 6, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- nrst  in  1  reset: synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = MULTU, 1 = DIVU; sampled with start.
- a_in  in  WIDTH  multiplicand / dividend.
- b_in  in  WIDTH  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; hi/lo valid from this cycle.
- div0  out  1  set with done when DIVU had b_in=0; cleared on the next accepted start.
- hi  out  WIDTH  product[63:32] / remainder.
- lo  out  WIDTH  product[31:0] / quotient.
- alu_own  out  1  high while the block drives the shared ALU.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_op  out  3  ALU opcode.
- alu_o  in  WIDTH  ALU result; combinational, same cycle.

Behaviour:
- Reset (nrst=0 at a clk edge) takes effect from any state, including mid-operation:
  - state=IDLE.
  - busy, done, div0, alu_own = 0.
  - hi, lo, counter, internal operand registers = 0.
  - The partial result is discarded.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1, op=0: mcand<=a_in, hi<=0, lo<=b_in, cnt<=0, div0<=0 -> MUL.
  - start=1, op=1, b_in!=0: dvsr<=b_in, hi<=0, lo<=a_in, cnt<=0, div0<=0 -> DIV.
  - start=1, op=1, b_in=0: hi<=a_in, lo<=all ones, div0<=1 -> FIN; no ALU use.
  - start=0: stay; hi/lo hold the last result.
- MUL iteration (alu_own=1, alu_op=0, alu_a=hi, alu_b=mcand):
  - carry = (alu_o < hi), unsigned.
  - If lo[0]=1: {hi,lo} <= {carry, alu_o, lo[WIDTH-1:1]}.
  - Else: {hi,lo} <= {1'b0, hi, lo[WIDTH-1:1]}.
  - cnt<=cnt+1; after the WIDTH-th iteration -> FIN.
- DIV iteration (restoring; alu_own=1, alu_op=1):
  - s = {hi, lo[WIDTH-1]} (WIDTH+1 bits).
  - alu_a = s[WIDTH-1:0]; alu_b = dvsr.
  - ge = s[WIDTH] | (s[WIDTH-1:0] >= dvsr), unsigned.
  - hi <= ge ? alu_o : s[WIDTH-1:0].
  - lo <= {lo[WIDTH-2:0], ge}.
  - cnt<=cnt+1; after WIDTH iterations -> FIN.
  - alu_o is still exact when s[WIDTH]=1, because the true difference is < dvsr.
- FIN: done=1, alu_own=0 -> IDLE. A start in FIN is ignored; it is accepted the following cycle.
- busy=1 in MUL, DIV and FIN.
- start while busy is ignored; the in-flight operation is unaffected.
- When alu_own=0: alu_a=0, alu_b=0, alu_op=0.
- Latency from the start edge to the done cycle:
  - WIDTH+1 cycles (33 at the default).
  - 1 cycle for divide-by-zero.
- hi/lo are intermediate while busy; the consumer reads them only at or after done.

Test Plan:
- MULTU a=7, b=6 -> done 33 cycles after start; hi=0x00000000, lo=0x0000002A; alu_own high for exactly 32 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises carry).
- DIVU a=100, b=7 -> lo=14, hi=2, div0=0. DIVU a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF, hi=0. DIVU a=0x80000000, b=0xFFFFFFFF -> lo=0, hi=0x80000000.
- DIVU a=0x1234, b=0 -> done the cycle after start; div0=1, hi=0x00001234, lo=0xFFFFFFFF, alu_own never asserted. The next MULTU start clears div0.
- MULTU 3x5 started, then start with DIVU 9/2 asserted on cycle 10 -> second request ignored; result hi=0, lo=15 at cycle 33.
- DIVU started, nrst=0 on cycle 12 -> following cycle: busy=0, alu_own=0, hi=lo=0, done never pulses. A new MULTU 2x3 then gives lo=6.
